// File: rtl/ofmap_collector_if.sv
// ofmap_collector_if
// Groups the conv-core result stream, the host drain handshake and the
// collector status flags.
//   slave  : the collector side. It receives in_valid/in_data/out_ready and
//            drives the FIFO head and the status flags.
//   master : the environment side (conv core plus host).
// Signals:
//   in_valid, in_data          conv core result stream
//   out_valid, out_ready       host drain handshake
//   out_data, out_row_last,
//   out_frame_last             FIFO head sample and its boundary tags
//   full, overflow, frame_done status
interface ofmap_collector_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_row_last;
  logic              out_frame_last;
  logic              full;
  logic              overflow;
  logic              frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_row_last, out_frame_last,
           full, overflow, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_row_last, out_frame_last,
           full, overflow, frame_done
  );
endinterface

// File: rtl/ofmap_collector.sv
// ofmap_collector
// Captures the conv core result stream and tags each sample with row and
// frame boundary flags. It buffers the tagged samples in a
// first-word-fall-through FIFO that the host drains over valid/ready.
// A sample that arrives while the FIFO is full, with no pop in the same
// cycle, is dropped. The drop sets a sticky overflow flag.
// Ports:
//   clk   rising-edge clock
//   rst   active-low asynchronous reset
//   clr   synchronous clear (FIFO, counters, overflow); wins over push/pop
//   en    capture enable; drain is unaffected
//   bus   ofmap_collector_if.slave (stream in, FIFO head out, status)
// Build option:
//   OFMAP_COLLECTOR_RELU_EN  when defined, negative samples (MSB set) are
//                            stored as zero.
module ofmap_collector #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 3,
  parameter int OUT_H  = 3,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  ofmap_collector_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_full;
  logic            r_overflow;
  logic            r_frame_done;

  logic            w_out_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_row_last;
  logic            w_frame_last;
  logic [DATA_W-1:0] w_data;
  logic [AW:0]     w_wr_ptr_nxt;
  logic [AW:0]     w_rd_ptr_nxt;
  logic            w_full_nxt;
  logic [EW-1:0]   w_head;

  // out_valid comes only from the pointers, so it never depends on out_ready.
  assign w_out_valid = (r_wr_ptr != r_rd_ptr);
  assign w_pop       = w_out_valid & bus.out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push      = !clr & en & bus.in_valid & (!r_full | w_pop);
  assign w_drop      = !clr & en & bus.in_valid & r_full & !w_pop;

  assign w_row_last   = (r_col == COL_LAST);
  assign w_frame_last = w_row_last & (r_row == ROW_LAST);

`ifdef OFMAP_COLLECTOR_RELU_EN
  assign w_data = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign w_data = bus.in_data;
`endif

  assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
  assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_full       <= w_full_nxt;
      r_frame_done <= w_push & w_frame_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        if (w_row_last) begin
          r_col <= '0;
          r_row <= w_frame_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // The storage needs no reset. Its contents are only visible while
  // out_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_frame_last, w_row_last, w_data};
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign bus.out_valid      = w_out_valid;
  assign bus.out_data       = w_out_valid ? w_head[DATA_W-1:0] : '0;
  assign bus.out_row_last   = w_out_valid & w_head[DATA_W];
  assign bus.out_frame_last = w_out_valid & w_head[DATA_W+1];
  assign bus.full           = r_full;
  assign bus.overflow       = r_overflow;
  assign bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_ofmap_collector.sv
module tb_ofmap_collector;

  typedef struct packed {
    logic       fl;
    logic       rl;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rst;
  logic clr;
  logic en;

  ofmap_collector_if #(.DATA_W(8)) bus ();

  ofmap_collector #(
    .DATA_W(8),
    .OUT_W (3),
    .OUT_H (3),
    .DEPTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .bus(bus.slave)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_col  = 0;
  int   m_row  = 0;
  int   fd_pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted head and checks gating when idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected nothing", bus.out_data);
        end else begin
          e = sb.pop_front();
          check("sb_data", 32'(bus.out_data), 32'(e.d));
          check("sb_row_last", 32'(bus.out_row_last), 32'(e.rl));
          check("sb_frame_last", 32'(bus.out_frame_last), 32'(e.fl));
        end
      end else if (!bus.out_valid) begin
        check("idle_gating", 32'({bus.out_data, bus.out_row_last, bus.out_frame_last}), 32'd0);
      end
      if (bus.frame_done) fd_pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle. When scored, the expected entry is
  // queued with tags from the column/row model.
  task automatic push(input logic [7:0] d, input logic [7:0] ed, input bit scored);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (scored) begin
      e.d  = ed;
      e.rl = (m_col == 2);
      e.fl = (m_col == 2) && (m_row == 2);
      sb.push_back(e);
      if (m_col == 2) begin
        m_col = 0;
        m_row = (m_row == 2) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((bus.out_valid || sb.size() != 0) && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", 32'(n < 64), 32'd1);
  endtask

  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef OFMAP_COLLECTOR_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    en  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset and idle
    #3;
    check("in_reset", 32'({bus.out_valid, bus.out_data, bus.out_row_last, bus.out_frame_last,
                           bus.full, bus.overflow, bus.frame_done}), 32'd0);
    #9 rst = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      check("idle", 32'({bus.out_valid, bus.out_data, bus.out_row_last, bus.out_frame_last,
                         bus.full, bus.overflow, bus.frame_done}), 32'd0);
      tick(1);
    end

    // Single frame, host always ready
    bus.out_ready = 1'b1;
    fd_pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      push(8'(i), 8'(i), 1'b1);
      if (i == 1) check("fwft_valid", 32'(bus.out_valid), 32'd1);
    end
    check("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    tick(1);
    check("frame_done_low", 32'(bus.frame_done), 32'd0);
    check("one_per_cycle_empty", 32'(bus.out_valid), 32'd0);
    tick(2);
    check("frame_done_count", 32'(fd_pulses), 32'd1);

    // Back-pressure and overflow
    bus.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push(8'(8'h10 + i), 8'(8'h10 + i), i < 16);
      if (i == 14) check("not_full_15", 32'(bus.full), 32'd0);
      if (i == 15) check("full_16", 32'({bus.full, bus.overflow}), 32'b10);
      if (i == 16) check("overflow_17", 32'(bus.overflow), 32'd1);
      if (i == 17) check("full_held", 32'(bus.full), 32'd1);
    end
    drain();
    check("full_after_drain", 32'(bus.full), 32'd0);
    check("overflow_sticky", 32'(bus.overflow), 32'd1);
    push(8'h99, 8'h99, 1'b1);
    push(8'h9A, 8'h9A, 1'b1);
    check("frame_done_cont", 32'(bus.frame_done), 32'd1);
    push(8'h9B, 8'h9B, 1'b1);
    drain();

    // Synchronous clear zeroes overflow and counters
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_col = 0;
    m_row = 0;
    check("clr_overflow", 32'({bus.overflow, bus.out_valid, bus.full}), 32'd0);
    for (int i = 0; i < 3; i++) push(8'(8'hA0 + i), 8'(8'hA0 + i), 1'b1);
    drain();

    // Full FIFO with a simultaneous pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), 8'(8'h30 + i), 1'b1);
    check("full_before_pop", 32'(bus.full), 32'd1);
    bus.out_ready = 1'b1;
    push(8'h55, 8'h55, 1'b1);
    check("push_pop_full", 32'({bus.full, bus.overflow}), 32'b10);
    tick(1);
    check("full_drops", 32'(bus.full), 32'd0);
    drain();

    // Asynchronous reset in the middle of a frame
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i), 8'h00, 1'b0);
    check("held_before_rst", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", 32'({bus.out_valid, bus.out_data, bus.out_row_last, bus.out_frame_last,
                                bus.full, bus.overflow, bus.frame_done}), 32'd0);
    #2 rst = 1'b1;
    m_col = 0;
    m_row = 0;
    tick(1);
    bus.out_ready = 1'b1;
    push(8'h70, 8'h70, 1'b1);
    push(8'h71, 8'h71, 1'b1);
    push(8'h72, 8'h72, 1'b1);
    drain();

    // Sign handling of the stored sample
    push(8'h80, relu(8'h80), 1'b1);
    push(8'hFF, relu(8'hFF), 1'b1);
    push(8'h7F, relu(8'h7F), 1'b1);
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ofmap_collector.md
# ofmap_collector

Output-side stage of the convolution accelerator. Captures the 8-bit result stream produced by the conv core, tags each sample with row/frame boundary flags, and buffers it in a first-word-fall-through FIFO drained by the host over a valid/ready handshake. It decouples the core's fixed-rate output from host back-pressure and reports data loss.

## Interface
- DATA_W, 8, sample width (matches conv core output)
- OUT_W, 3, output feature-map columns per row
- OUT_H, 3, output feature-map rows per frame
- DEPTH, 16, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  active-low reset; asynchronous assertion; clears all state
- clr  in  1  synchronous clear: empties FIFO, zeroes counters, clears overflow
- en  in  1  capture enable; when 0, in_valid is ignored (drain continues)
- in_valid  in  1  conv core result valid this cycle
- in_data  in  DATA_W  conv core result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head this cycle
- out_data  out  DATA_W  FIFO head sample
- out_row_last  out  1  head is last column of a row
- out_frame_last  out  1  head is last sample of a frame
- full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: a valid sample was dropped
- frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted into FIFO

## Operation
- Push condition: rst high, !clr, en & in_valid & (!full | (out_valid & out_ready)).
- Pop condition: out_valid & out_ready.
- Each FIFO entry stores {frame_last, row_last, data}; row_last = (col == OUT_W-1); frame_last = row_last & (row == OUT_H-1).
- Counters col (0..OUT_W-1) and row (0..OUT_H-1) advance only on push; col wraps to 0 and increments row; row wraps to 0 after the frame's last sample.
- Dropped sample (en & in_valid & full & no pop): not stored, counters do not advance, overflow set to 1 and held until rst or clr.
- Empty FIFO: out_valid=0, out_data=0, out_row_last=0, out_frame_last=0 (outputs gated, never stale).
- Pointers are log2(DEPTH) bits plus one wrap bit; full when pointer bits equal and wrap bits differ; empty when all equal.
- clr has priority over push and pop in the same cycle.
- rst asserted mid-frame: FIFO emptied, counters zeroed; next accepted sample is row 0 col 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_row_last 0, out_frame_last 0, full 0, overflow 0, frame_done 0.
- Push at edge N → out_valid=1 and data visible from edge N (one-cycle latency, FWFT); no extra read cycle.
- Pop at edge N → next entry (if any) presented immediately after edge N; back-to-back pops sustain one sample per cycle.
- Simultaneous push and pop when full: both occur, occupancy unchanged, full stays 1, no overflow.
- Simultaneous push and pop when empty: push only (out_valid was 0).
- frame_done registered: high for exactly the cycle after the edge that pushed a frame_last entry.
- full is registered from occupancy; reflects state after the most recent edge.
- out_valid must not depend combinationally on out_ready.

## Configuration
- OFMAP_COLLECTOR_RELU_EN defined: in_data is treated as two's-complement; negative values (MSB=1) are stored as 0, others unchanged.
- Not defined: in_data stored unmodified; no sign interpretation.

## Test plan
- Reset/idle: rst low then high, no inputs → all outputs 0 for 10 cycles.
- Single frame: push 9 samples 1..9 with out_ready=1 → out_data 1..9 one per cycle, out_row_last on 3,6,9, out_frame_last on 9 only, frame_done pulses once.
- Back-pressure/overflow: out_ready=0, push 18 samples 0x10..0x21 with DEPTH=16 → full=1 after 16th, overflow=1 after 17th; drain yields exactly 0x10..0x1F; counters reflect 16 accepted samples (row/col tags continue from sample 16).
- Full with simultaneous pop: fill to 16, then push 0x55 while out_ready=1 → no overflow, 0x55 appears as 16th drained entry after the original 15 remaining.
- Mid-frame reset: push 4 samples, assert rst async between edges → outputs 0 immediately; after release push 3 samples → third carries out_row_last=1.
- Macro: with OFMAP_COLLECTOR_RELU_EN push 0x80, 0xFF, 0x7F → drain 0x00, 0x00, 0x7F; without macro → 0x80, 0xFF, 0x7F.
